mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.

---
 rtl/mult_div_unit_if.sv | 15 +
 rtl/mult_div_unit.sv | 94 +++++++++
 tb/tb_mult_div_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operand, control and result bundle between the datapath and the mult/div unit
interface mult_div_unit_if #(parameter int DATA_W = 32);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              hi_wr;
    logic              lo_wr;
    logic              rd_sel;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] read_data;
    modport master (output start, op, rs_data, rt_data, hi_wr, lo_wr, rd_sel, input busy, done, read_data);
    modport slave  (input start, op, rs_data, rt_data, hi_wr, lo_wr, rd_sel, output busy, done, read_data);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers
module mult_div_unit #(
    parameter int DATA_W = 32,
    parameter int ITER   = 32
) (
    input logic clk,
    input logic rst,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    state_t              r_state, w_next;
    logic [CW-1:0]       r_cnt;
    logic [2*DATA_W-1:0] r_acc, w_prod;
    logic [DATA_W-1:0]   r_m, r_hi, r_lo, w_abs_a, w_abs_b, w_q, w_r, w_diff;
    logic [DATA_W:0]     w_sum;
    logic                r_div, r_neg_q, r_neg_r, r_bz, w_sa, w_sb, w_ge;
    assign w_sa    = ~bus.op[0] & bus.rs_data[DATA_W-1];
    assign w_sb    = ~bus.op[0] & bus.rt_data[DATA_W-1];
    assign w_abs_a = w_sa ? -bus.rs_data : bus.rs_data;
    assign w_abs_b = w_sb ? -bus.rt_data : bus.rt_data;
    assign w_sum   = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_ge    = r_acc[2*DATA_W-1:DATA_W-1] >= {1'b0, r_m};
    assign w_diff  = r_acc[2*DATA_W-2:DATA_W-1] - r_m;
    assign w_prod  = r_neg_q ? -r_acc : r_acc;
    assign w_q     = r_acc[DATA_W-1:0];
    assign w_r     = r_acc[2*DATA_W-1:DATA_W];
    assign bus.read_data = bus.rd_sel ? r_hi : r_lo;
    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    // next-state and status outputs
    always_comb begin
        w_next   = r_state;
        bus.busy = r_state != IDLE;
        bus.done = r_state == DONE;
        case (r_state)
            IDLE:     w_next = bus.start ? (bus.op[1] ? DIV : MUL) : IDLE;
            MUL, DIV: w_next = r_cnt == LAST ? FIX : r_state;
            FIX:      w_next = DONE;
            default:  w_next = IDLE;
        endcase
    end
    // operand latch, shift-add / restoring iterations, sign fix-up and HI/LO writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_m     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_bz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.hi_wr) r_hi <= bus.rs_data;
                    if (bus.lo_wr) r_lo <= bus.rs_data;
                    if (bus.start) begin
                        r_cnt   <= '0;
                        r_div   <= bus.op[1];
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        r_bz    <= bus.rt_data == '0;
                        r_m     <= bus.op[1] ? w_abs_b : w_abs_a;
                        r_acc   <= {{DATA_W{1'b0}}, bus.op[1] ? w_abs_a : w_abs_b};
                    end
                end
                MUL: begin
                    r_acc <= {w_sum, r_acc[DATA_W-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                DIV: begin
                    r_acc <= w_ge ? {w_diff, r_acc[DATA_W-2:0], 1'b1} : {r_acc[2*DATA_W-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    if (r_div) begin
                        r_lo <= r_bz ? '1 : (r_neg_q ? -w_q : w_q);
                        r_hi <= r_neg_r ? -w_r : w_r;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    mult_div_unit_if #(.DATA_W(32)) bus();
    mult_div_unit #(.DATA_W(32), .ITER(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic rd(output logic [31:0] hi, output logic [31:0] lo);
        bus.rd_sel = 1'b0;
        #1 lo = bus.read_data;
        bus.rd_sel = 1'b1;
        #1 hi = bus.read_data;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        bus.op = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 60 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                bus.start = 1'b0;
                bus.rs_data = 32'hDEAD_BEEF;
                bus.rt_data = 32'h0BAD_F00D;
            end
            if (bus.done) lat = i;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        logic [31:0] hi, lo;
        rd(hi, lo);
        total += 4;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
    endtask

    task automatic test_ops(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] hi, lo;
        int lat;
        do_op(op, a, b, lat);
        rd(hi, lo);
        total += 3;
        if (lat !== 34) begin bad++; $display("FAIL %s_latency: got %0d want 34", name, lat); end
        if (hi !== ehi) begin bad++; $display("FAIL %s_hi: got %h want %h", name, hi, ehi); end
        if (lo !== elo) begin bad++; $display("FAIL %s_lo: got %h want %h", name, lo, elo); end
    endtask

    task automatic test_mul;
        test_ops("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        test_ops("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        test_ops("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        test_ops("multu_mid", 2'b01, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780);
    endtask

    task automatic test_div;
        test_ops("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        test_ops("divu_small", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        test_ops("divu_one", 2'b11, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF);
    endtask

    task automatic test_div_edge;
        test_ops("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        test_ops("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        test_ops("div_zero_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    endtask

    task automatic test_mtx;
        logic [31:0] hi, lo, mid;
        int lat;
        bus.rs_data = 32'h0000_55AA;
        bus.hi_wr = 1'b1;
        bus.lo_wr = 1'b1;
        @(posedge clk); #1;
        bus.hi_wr = 1'b0;
        bus.lo_wr = 1'b0;
        rd(hi, lo);
        total += 2;
        if (hi !== 32'h55AA) begin bad++; $display("FAIL mt_both_hi: got %h want 000055aa", hi); end
        if (lo !== 32'h55AA) begin bad++; $display("FAIL mt_both_lo: got %h want 000055aa", lo); end
        bus.op = 2'b01;
        bus.rs_data = 32'd9;
        bus.rt_data = 32'd2;
        bus.start = 1'b1;
        bus.lo_wr = 1'b1;
        lat = -1;
        mid = 32'h0;
        for (int i = 1; i <= 60 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin bus.start = 1'b0; bus.lo_wr = 1'b0; bus.rs_data = 32'h0; end
            if (i == 3) begin bus.rd_sel = 1'b0; #1 mid = bus.read_data; end
            if (bus.done) lat = i;
        end
        @(posedge clk); #1;
        rd(hi, lo);
        total += 4;
        if (mid !== 32'd9) begin bad++; $display("FAIL mtlo_with_start_mid: got %h want 00000009", mid); end
        if (lat !== 34) begin bad++; $display("FAIL mtlo_with_start_latency: got %0d want 34", lat); end
        if (hi !== 32'h0) begin bad++; $display("FAIL mtlo_with_start_hi: got %h want 0", hi); end
        if (lo !== 32'd18) begin bad++; $display("FAIL mtlo_with_start_lo: got %h want 00000012", lo); end
    endtask

    task automatic test_busy_ignore;
        logic [31:0] hi, lo;
        int lat, nd;
        logic bmid;
        bus.op = 2'b01;
        bus.rs_data = 32'd3;
        bus.rt_data = 32'd5;
        bus.start = 1'b1;
        lat = -1;
        nd = 0;
        bmid = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk); #1;
            if (i == 1) bus.start = 1'b0;
            if (i == 5) bmid = bus.busy;
            if (i == 10) begin
                bus.start = 1'b1; bus.op = 2'b10; bus.rs_data = 32'h1234; bus.rt_data = 32'd3; bus.hi_wr = 1'b1;
            end
            if (i == 11) begin bus.start = 1'b0; bus.hi_wr = 1'b0; end
            if (bus.done) begin nd++; if (lat < 0) lat = i; end
        end
        rd(hi, lo);
        total += 6;
        if (bmid !== 1'b1) begin bad++; $display("FAIL busy_mid: got %b want 1", bmid); end
        if (lat !== 34) begin bad++; $display("FAIL busy_latency: got %0d want 34", lat); end
        if (nd !== 1) begin bad++; $display("FAIL busy_done_count: got %0d want 1", nd); end
        if (hi !== 32'h0) begin bad++; $display("FAIL busy_hi: got %h want 0", hi); end
        if (lo !== 32'd15) begin bad++; $display("FAIL busy_lo: got %h want 0000000f", lo); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_rst_mid;
        logic [31:0] hi, lo;
        int nd;
        bus.rs_data = 32'h77;
        bus.hi_wr = 1'b1;
        bus.lo_wr = 1'b1;
        @(posedge clk); #1;
        bus.hi_wr = 1'b0;
        bus.lo_wr = 1'b0;
        bus.op = 2'b00;
        bus.rs_data = 32'h1234;
        bus.rt_data = 32'h5678;
        bus.start = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (i == 1) bus.start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rd(hi, lo);
        total += 4;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
        if (hi !== 32'h0) begin bad++; $display("FAIL rst_mid_hi: got %h want 0", hi); end
        if (lo !== 32'h0) begin bad++; $display("FAIL rst_mid_lo: got %h want 0", lo); end
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) nd++;
        end
        if (nd !== 0) begin bad++; $display("FAIL rst_mid_done: got %0d pulses want 0", nd); end
        bus.rs_data = 32'hA5A5_A5A5;
        bus.lo_wr = 1'b1;
        @(posedge clk); #1;
        bus.lo_wr = 1'b0;
        bus.rd_sel = 1'b0;
        #1;
        total += 1;
        if (bus.read_data !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL rst_mid_mtlo: got %h want a5a5a5a5", bus.read_data);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.rs_data = 32'h0;
        bus.rt_data = 32'h0;
        bus.hi_wr = 1'b0;
        bus.lo_wr = 1'b0;
        bus.rd_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset;
        test_mul;
        test_div;
        test_div_edge;
        test_mtx;
        test_busy_ignore;
        test_rst_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
